// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single RAM port arbiter between instruction fetch and data memory
module mem_port_arbiter #(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_byteen,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic [29:0] ram_address,
    output logic [31:0] ram_data,
    output logic [3:0]  ram_byteena,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    output logic        busy
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    typedef enum logic [0:0] {
        IDLE,
        RD_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        owner_dm;
    logic [3:0]  streak;
    logic [29:0] addr_q;
    logic        grant_dm;
    logic        grant_if;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

    assign busy = (state == RD_WAIT);

    always_comb begin
        grant_dm    = 1'b0;
        grant_if    = 1'b0;
        state_next  = state;
        ram_address = addr_q;
        ram_data    = dm_wdata;
        ram_byteena = 4'b1111;
        ram_wren    = 1'b0;
        if (reset) begin
            ram_address = 30'd0;
        end else if (state == IDLE) begin
            // Data side wins unless fetch has already been passed over STREAK_MAX times
            if (dm_req && (!if_req || streak != STREAK_MAX)) begin
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
            if (grant_dm) begin
                ram_address = dm_addr[31:2];
                if (dm_we) begin
                    ram_byteena = dm_byteen;
                    ram_wren    = (dm_byteen != 4'b0000);
                end else begin
                    state_next = RD_WAIT;
                end
            end else if (grant_if) begin
                ram_address = if_addr[31:2];
                state_next  = RD_WAIT;
            end
        end else begin
            state_next = IDLE;
        end
    end

    assign dm_gnt = grant_dm;
    assign if_gnt = grant_if;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_dm  <= 1'b0;
            streak    <= 4'd0;
            addr_q    <= 30'd0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= 32'd0;
            dm_rdata  <= 32'd0;
        end else begin
            state     <= state_next;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if (grant_dm || grant_if) begin
                addr_q   <= ram_address;
                owner_dm <= grant_dm;
                if (grant_dm && if_req) begin
                    if (streak != STREAK_MAX) begin
                        streak <= streak + 4'd1;
                    end
                end else begin
                    streak <= 4'd0;
                end
            end
            // RAM output is valid one cycle after the address was registered
            if (state == RD_WAIT) begin
                if (owner_dm) begin
                    dm_rdata  <= ram_q;
                    dm_rvalid <= 1'b1;
                end else begin
                    if_rdata  <= ram_q;
                    if_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteen;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [29:0] ram_address;
    logic [31:0] ram_data;
    logic [3:0]  ram_byteena;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int overlap_cnt = 0;

    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    mem_port_arbiter #(.MAX_DM_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_byteen(dm_byteen), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_byteena(ram_byteena), .ram_wren(ram_wren),
        .ram_q(ram_q), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-address RAM model with byte enables
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteena[b]) mem[ram_address[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
            end
        end
        ram_q <= mem[ram_address[7:0]];
    end

    always @(negedge clk) begin
        if (if_rvalid && dm_rvalid) overlap_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_byteen = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_we = 1; pre_idx = idx; pre_data = data;
        step();
        pre_we = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        if_req = 1; if_addr = 32'h40; dm_req = 1; dm_addr = 32'h80;
        step();
        @(negedge clk);
        checks++;
        if (if_gnt !== 0 || dm_gnt !== 0) begin
            errors++; $display("FAIL reset_gnt: got if=%b dm=%b want 0 0", if_gnt, dm_gnt);
        end
        checks++;
        if (ram_wren !== 0 || ram_address !== 30'd0 || ram_byteena !== 4'b1111) begin
            errors++; $display("FAIL reset_ram: got wren=%b addr=%h be=%b want 0 0 1111", ram_wren, ram_address, ram_byteena);
        end
        checks++;
        if (if_rvalid !== 0 || dm_rvalid !== 0 || if_rdata !== 0 || dm_rdata !== 0 || busy !== 0) begin
            errors++; $display("FAIL reset_regs: got ifv=%b dmv=%b ifd=%h dmd=%h busy=%b want all 0", if_rvalid, dm_rvalid, if_rdata, dm_rdata, busy);
        end
        apply_reset();
    endtask

    task automatic test_if_read();
        preload(8'd4, 32'h2408000A);
        if_req = 1; if_addr = 32'h00000010;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1 || dm_gnt !== 0 || ram_address !== 30'd4 || ram_wren !== 0 || busy !== 0) begin
            errors++; $display("FAIL if_grant: got gnt=%b dmgnt=%b addr=%h wren=%b busy=%b want 1 0 4 0 0", if_gnt, dm_gnt, ram_address, ram_wren, busy);
        end
        step();
        if_req = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1 || if_rvalid !== 0 || if_gnt !== 0 || ram_address !== 30'd4) begin
            errors++; $display("FAIL if_wait: got busy=%b rvalid=%b gnt=%b addr=%h want 1 0 0 4", busy, if_rvalid, if_gnt, ram_address);
        end
        step();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1 || if_rdata !== 32'h2408000A || dm_rvalid !== 0 || busy !== 0) begin
            errors++; $display("FAIL if_data: got rvalid=%b rdata=%h busy=%b want 1 2408000a 0", if_rvalid, if_rdata, busy);
        end
        step();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 0 || if_rdata !== 32'h2408000A) begin
            errors++; $display("FAIL if_hold: got rvalid=%b rdata=%h want 0 2408000a", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_byte_store();
        step();
        preload(8'h40, 32'h11223344);
        dm_req = 1; dm_we = 1; dm_addr = 32'h00000103; dm_wdata = 32'h000000AB; dm_byteen = 4'b0001;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1 || ram_wren !== 1 || ram_address !== 30'h40 || ram_byteena !== 4'b0001 || ram_data !== 32'hAB) begin
            errors++; $display("FAIL store_grant: got gnt=%b wren=%b addr=%h be=%b data=%h want 1 1 40 0001 ab", dm_gnt, ram_wren, ram_address, ram_byteena, ram_data);
        end
        step();
        dm_we = 0; dm_addr = 32'h00000100; dm_byteen = 4'b0000;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1 || busy !== 0 || dm_rvalid !== 0 || ram_byteena !== 4'b1111 || ram_wren !== 0) begin
            errors++; $display("FAIL store_b2b: got gnt=%b busy=%b rvalid=%b be=%b wren=%b want 1 0 0 1111 0", dm_gnt, busy, dm_rvalid, ram_byteena, ram_wren);
        end
        step();
        dm_req = 0;
        step();
        @(negedge clk);
        checks++;
        if (dm_rvalid !== 1 || dm_rdata !== 32'h112233AB) begin
            errors++; $display("FAIL store_readback: got rvalid=%b rdata=%h want 1 112233ab", dm_rvalid, dm_rdata);
        end
    endtask

    task automatic test_contention();
        logic exp_dm [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic got_dm [6];
        int   cyc [6];
        int   n = 0;
        apply_reset();
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (dm_gnt || if_gnt) begin
                got_dm[n] = dm_gnt;
                cyc[n] = c;
                n++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL contention_count: got %0d grants want 6", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_dm[i] !== exp_dm[i]) begin
                errors++; $display("FAIL contention_order[%0d]: got dm=%b want %b", i, got_dm[i], exp_dm[i]);
            end
            if (i > 0) begin
                checks++;
                if (cyc[i] - cyc[i-1] !== 2) begin
                    errors++; $display("FAIL contention_gap[%0d]: got %0d want 2", i, cyc[i] - cyc[i-1]);
                end
            end
        end
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1 || if_gnt !== 0) begin
            errors++; $display("FAIL sim_first: got dm=%b if=%b want 1 0", dm_gnt, if_gnt);
        end
        step();
        dm_req = 0;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 0 || if_gnt !== 0 || busy !== 1) begin
            errors++; $display("FAIL sim_wait: got dm=%b if=%b busy=%b want 0 0 1", dm_gnt, if_gnt, busy);
        end
        step();
        @(negedge clk);
        checks++;
        if (dm_rvalid !== 1 || dm_rdata !== 32'h112233AB || if_gnt !== 1 || ram_address !== 30'd4) begin
            errors++; $display("FAIL sim_pulse: got dmv=%b dmd=%h ifgnt=%b addr=%h want 1 112233ab 1 4", dm_rvalid, dm_rdata, if_gnt, ram_address);
        end
        step();
        if_req = 0;
        @(negedge clk);
        checks++;
        if (dm_rvalid !== 0 || if_rvalid !== 0) begin
            errors++; $display("FAIL sim_gap: got dmv=%b ifv=%b want 0 0", dm_rvalid, if_rvalid);
        end
        step();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1 || if_rdata !== 32'h2408000A || dm_rvalid !== 0) begin
            errors++; $display("FAIL sim_if_data: got ifv=%b ifd=%h dmv=%b want 1 2408000a 0", if_rvalid, if_rdata, dm_rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        step();
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1) begin
            errors++; $display("FAIL rst_mid_grant: got %b want 1", dm_gnt);
        end
        step();
        dm_req = 0; reset = 1;
        @(negedge clk);
        checks++;
        if (ram_address !== 30'd0 || ram_byteena !== 4'b1111 || if_gnt !== 0 || dm_gnt !== 0) begin
            errors++; $display("FAIL rst_mid_outputs: got addr=%h be=%b if=%b dm=%b want 0 1111 0 0", ram_address, ram_byteena, if_gnt, dm_gnt);
        end
        step();
        reset = 0;
        @(negedge clk);
        checks++;
        if (dm_rvalid !== 0 || dm_rdata !== 32'd0 || busy !== 0) begin
            errors++; $display("FAIL rst_mid_suppress: got dmv=%b dmd=%h busy=%b want 0 0 0", dm_rvalid, dm_rdata, busy);
        end
        step();
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1 || ram_address !== 30'd4) begin
            errors++; $display("FAIL rst_mid_regrant: got gnt=%b addr=%h want 1 4", if_gnt, ram_address);
        end
        step();
        if_req = 0;
        repeat (2) step();
    endtask

    task automatic test_zero_enable_store();
        preload(8'h41, 32'hCAFEBABE);
        dm_req = 1; dm_we = 1; dm_addr = 32'h104; dm_wdata = 32'hFFFFFFFF; dm_byteen = 4'b0000;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1 || ram_wren !== 0 || ram_byteena !== 4'b0000 || busy !== 0) begin
            errors++; $display("FAIL zero_be_grant: got gnt=%b wren=%b be=%b busy=%b want 1 0 0000 0", dm_gnt, ram_wren, ram_byteena, busy);
        end
        step();
        dm_we = 0;
        step();
        dm_req = 0;
        step();
        @(negedge clk);
        checks++;
        if (dm_rvalid !== 1 || dm_rdata !== 32'hCAFEBABE) begin
            errors++; $display("FAIL zero_be_readback: got rvalid=%b rdata=%h want 1 cafebabe", dm_rvalid, dm_rdata);
        end
        step();
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap_cnt !== 0) begin
            errors++; $display("FAIL rvalid_overlap: got %0d cycles want 0", overlap_cnt);
        end
    endtask

    initial begin
        pre_we = 0; pre_idx = 0; pre_data = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_if_read();
        test_byte_store();
        test_contention();
        test_simultaneous();
        test_reset_mid_read();
        test_zero_enable_store();
        test_no_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single CPU-side RAM port between two requesters: instruction fetch (IF, read-only) and data memory (DM, load/store with byte enables).
- Replaces the fixed address mux between PC and ALU result, so the pipeline controller can stall on a grant instead of hard-sequencing fetch and memory cycles.
- Sits between the pipeline stage logic and the RAM macro. The RAM has a registered address, so read data appears one cycle after the address is presented.
- Data accesses have priority; a streak limit prevents fetch starvation.

Parameters:
- MAX_DM_STREAK, 4: maximum consecutive DM grants while if_req is pending. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- dm_req  in  1  data request; held with dm_* until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address; bits [1:0] ignored
- dm_wdata  in  32  store data, already lane-aligned
- dm_byteen  in  4  store byte enables; bit 3 = bits [31:24]
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  one-cycle pulse: dm_rdata valid (loads only)
- dm_rdata  out  32  loaded word
- ram_address  out  30  word address to RAM
- ram_data  out  32  RAM write data
- ram_byteena  out  4  RAM byte enables
- ram_wren  out  1  RAM write strobe
- ram_q  in  32  RAM read data, valid the cycle after address
- busy  out  1  high while in RD_WAIT

Behaviour:
- FSM states: IDLE, RD_WAIT. Internal registers: owner (IF/DM), streak[3:0].
- Reset values:
  - State IDLE, streak 0.
  - if_rvalid = dm_rvalid = 0; if_rdata = dm_rdata = 0.
  - While reset is high: gnts 0, ram_wren 0, ram_address 0, ram_byteena 4'b1111.
- Arbitration (IDLE only, combinational):
  - dm_req alone: DM wins. if_req alone: IF wins.
  - Both requesting: DM wins unless streak == MAX_DM_STREAK, in which case IF wins.
  - No request: no gnt; ram_wren 0; ram_address holds its last value.
- The winner's gnt is high for exactly one cycle, the grant cycle T. In that cycle:
  - ram_address = addr[31:2].
  - For a DM store: ram_data = dm_wdata, ram_byteena = dm_byteen, ram_wren = 1 if dm_byteen != 0, else 0 (gnt is still given).
  - For any read: ram_byteena = 4'b1111, ram_wren = 0.
- Store: completes in T, state stays IDLE, no rvalid. Back-to-back grants are possible every cycle.
- Read: at T the owner is latched and the state goes to RD_WAIT.
  - In RD_WAIT (T+1): no gnt; ram_wren 0; ram_address holds.
  - At the end of T+1: the owner's rdata <= ram_q, the owner's rvalid <= 1, state <= IDLE.
  - Net result: rvalid and rdata are visible at T+2 for exactly one cycle. rdata holds after the pulse.
  - A new grant may issue at T+2, concurrently with the rvalid pulse.
- Streak update, at each IDLE grant:
  - DM granted and if_req high: streak <= streak + 1, saturating at MAX_DM_STREAK.
  - IF granted, or if_req low: streak <= 0.
  - Streak never advances in RD_WAIT.
- Both rvalids are never high in the same cycle. At most one gnt is high per cycle.
- Requests that drop before their gnt are simply not served; no error is flagged.
- Reset asserted in RD_WAIT: FSM goes to IDLE, the pending rvalid is suppressed, rdata is cleared to 0.
- busy = (state == RD_WAIT).

Test Plan:
- Reset, then IF read: if_req=1, if_addr=0x00000010, RAM word 4 = 0x2408000A → if_gnt at T with ram_address=4; if_rvalid=1 and if_rdata=0x2408000A only at T+2; busy=1 at T+1.
- Byte store: dm_req=1, dm_we=1, dm_addr=0x00000103, dm_wdata=0x000000AB, dm_byteen=4'b0001 → dm_gnt and ram_wren at T, ram_address=0x40, ram_byteena=0001; then read back 0x100 → byte [7:0]=0xAB at T+2, other bytes unchanged.
- Contention: if_req and dm_req both held high continuously, DM issuing loads, MAX_DM_STREAK=4 → grants are DM,DM,DM,DM,IF,DM..., each load 2 cycles apart; the IF grant occurs exactly on the 5th grant.
- Simultaneous pulse: DM load granted at T, IF read pending → if_gnt at T+2 coincident with dm_rvalid; if_rvalid at T+4; the two rvalids never overlap.
- Reset mid-read: assert reset at T+1 of a DM load → dm_rvalid stays 0 at T+2, dm_rdata=0, state IDLE; an IF request at T+3 (reset low) is granted immediately.
- Zero-enable store: dm_we=1, dm_byteen=0 → dm_gnt=1, ram_wren=0, RAM contents unchanged.
